// File: rtl/pbit_frame_packer.sv
// -----------------------------------------------------------------------------
// pbit_frame_packer
//
// Purpose: on a snap_req pulse, captures the live p-bit vector into a shadow
// register and streams it out over an AXI4-Stream master as
// FRAME_COUNT = ceil(TOTAL_NUM_PBITS/DATA_WIDTH) beats. The last beat is
// zero-padded above TOTAL_NUM_PBITS, and tkeep marks only its used bytes.
// Requests that arrive while a snapshot is in flight are dropped and counted.
//
// Optional feature: define PBIT_PACKER_HEADER_EN to prepend one header beat
// {zeros, FRAME_COUNT[15:0], seq_num} to every snapshot.
//
// Ports:
//   clk            single clock
//   rst            asynchronous, active-high reset
//   pbits          live p-bit states (TOTAL_NUM_PBITS)
//   snap_req       request to capture and stream one snapshot
//   busy           a snapshot is in flight
//   m_axis_tdata   stream data (DATA_WIDTH)
//   m_axis_tkeep   valid-byte mask (DATA_WIDTH/8)
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready (input)
//   m_axis_tlast   final beat of a snapshot
//   seq_num        count of accepted snapshots (wraps)
//   drop_count     count of ignored snap_req cycles (saturates at 0xFFFF)
// -----------------------------------------------------------------------------
module pbit_frame_packer #(
  parameter int DATA_WIDTH      = 256,
  parameter int TOTAL_NUM_PBITS = 1024,
  parameter int SEQ_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TOTAL_NUM_PBITS-1:0]   pbits,
  input  logic                         snap_req,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [SEQ_WIDTH-1:0]         seq_num,
  output logic [15:0]                  drop_count
);

  localparam int KEEP_W      = DATA_WIDTH / 8;
  localparam int FRAME_COUNT = (TOTAL_NUM_PBITS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SHADOW_W    = FRAME_COUNT * DATA_WIDTH;
  localparam int LAST_BITS   = TOTAL_NUM_PBITS - (FRAME_COUNT - 1) * DATA_WIDTH;
  localparam int LAST_BYTES  = (LAST_BITS + 7) / 8;
  localparam int BEAT_W      = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
  // Index width exactly matches the shadow's select range; the largest
  // offset ever used, (FRAME_COUNT-1)*DATA_WIDTH, always fits.
  localparam int OFF_W       = $clog2(SHADOW_W);

  localparam logic [KEEP_W-1:0] FULL_KEEP = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_COUNT - 1);
  localparam logic [OFF_W-1:0]  OFF_STEP  = OFF_W'(DATA_WIDTH);
  localparam logic              ONE_BEAT  = 1'(FRAME_COUNT == 1);
`ifdef PBIT_PACKER_HEADER_EN
  localparam logic [15:0]       FRAME_COUNT_16 = 16'(FRAME_COUNT);
`endif

`ifdef PBIT_PACKER_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HDR = 2'd2} state_t;
  localparam state_t START_ST = HDR;
`else
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  localparam state_t START_ST = SEND;
`endif

  // Byte mask for a data beat: partial only on the final beat.
  function automatic logic [KEEP_W-1:0] keep_for(input logic is_last);
    return is_last ? LAST_KEEP : FULL_KEEP;
  endfunction

  state_t                state_r, state_n_s;
  logic [SHADOW_W-1:0]   shadow_r, shadow_n_s;
  logic [DATA_WIDTH-1:0] tdata_r, tdata_n_s;
  logic [KEEP_W-1:0]     tkeep_r, tkeep_n_s;
  logic                  tlast_r, tlast_n_s;
  logic                  tvalid_r, tvalid_n_s;
  logic                  busy_r, busy_n_s;
  logic [BEAT_W-1:0]     beat_r, beat_n_s, beat_inc_s;
  logic [OFF_W-1:0]      off_r, off_n_s, off_inc_s;
  logic [SEQ_WIDTH-1:0]  seq_r, seq_n_s, seq_inc_s;
  logic [15:0]           drop_r, drop_n_s;
  logic                  hs_s, last_hs_s, accept_s;
  logic [SHADOW_W-1:0]   pad_s;
  logic                  next_last_s;
`ifdef PBIT_PACKER_HEADER_EN
  logic [DATA_WIDTH-1:0] hdr_s;
`endif

  // Next-state and next-output logic for the capture/stream FSM.
  always_comb begin
    state_n_s  = state_r;
    shadow_n_s = shadow_r;
    tdata_n_s  = tdata_r;
    tkeep_n_s  = tkeep_r;
    tlast_n_s  = tlast_r;
    tvalid_n_s = tvalid_r;
    beat_n_s   = beat_r;
    off_n_s    = off_r;
    seq_n_s    = seq_r;
    drop_n_s   = drop_r;

    hs_s       = tvalid_r & m_axis_tready;
    // tlast is only ever set on the final data beat, so this marks the
    // handshake that completes a snapshot.
    last_hs_s  = hs_s & tlast_r;
    accept_s   = snap_req & ((state_r == IDLE) | ((state_r == SEND) & last_hs_s));

    seq_inc_s   = seq_r + SEQ_WIDTH'(1);
    off_inc_s   = off_r + OFF_STEP;
    beat_inc_s  = beat_r + BEAT_W'(1);
    next_last_s = (beat_inc_s == LAST_BEAT);

    pad_s = '0;
    pad_s[TOTAL_NUM_PBITS-1:0] = pbits;

`ifdef PBIT_PACKER_HEADER_EN
    hdr_s = '0;
    hdr_s[SEQ_WIDTH-1:0]   = seq_inc_s;
    hdr_s[SEQ_WIDTH +: 16] = FRAME_COUNT_16;
`endif

    if (accept_s) begin
      // Beat 0 (or the header) is built straight from the incoming values,
      // since the shadow and seq_num only update on this same edge.
      state_n_s  = START_ST;
      shadow_n_s = pad_s;
      seq_n_s    = seq_inc_s;
      tvalid_n_s = 1'b1;
      beat_n_s   = '0;
      off_n_s    = '0;
`ifdef PBIT_PACKER_HEADER_EN
      tdata_n_s  = hdr_s;
      tkeep_n_s  = FULL_KEEP;
      tlast_n_s  = 1'b0;
`else
      tdata_n_s  = pad_s[DATA_WIDTH-1:0];
      tkeep_n_s  = keep_for(ONE_BEAT);
      tlast_n_s  = ONE_BEAT;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_n_s = IDLE;
        end
`ifdef PBIT_PACKER_HEADER_EN
        HDR: begin
          if (hs_s) begin
            state_n_s = SEND;
            tdata_n_s = shadow_r[DATA_WIDTH-1:0];
            tkeep_n_s = keep_for(ONE_BEAT);
            tlast_n_s = ONE_BEAT;
          end else begin
            state_n_s = HDR;
          end
        end
`endif
        SEND: begin
          if (last_hs_s) begin
            state_n_s  = IDLE;
            tvalid_n_s = 1'b0;
            tlast_n_s  = 1'b0;
            tdata_n_s  = '0;
            tkeep_n_s  = '0;
            beat_n_s   = '0;
            off_n_s    = '0;
          end else if (hs_s) begin
            beat_n_s  = beat_inc_s;
            off_n_s   = off_inc_s;
            tdata_n_s = shadow_r[off_inc_s +: DATA_WIDTH];
            tlast_n_s = next_last_s;
            tkeep_n_s = keep_for(next_last_s);
          end else begin
            state_n_s = SEND;
          end
        end
        default: begin
          state_n_s  = IDLE;
          tvalid_n_s = 1'b0;
          tlast_n_s  = 1'b0;
          tdata_n_s  = '0;
          tkeep_n_s  = '0;
          beat_n_s   = '0;
          off_n_s    = '0;
        end
      endcase
    end

    if (snap_req & ~accept_s & (state_r != IDLE)) begin
      if (drop_r != 16'hFFFF) begin
        drop_n_s = drop_r + 16'd1;
      end else begin
        drop_n_s = drop_r;
      end
    end else begin
      drop_n_s = drop_r;
    end

    busy_n_s = (state_n_s != IDLE);
  end

  // State, shadow, counters and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      shadow_r <= '0;
      tdata_r  <= '0;
      tkeep_r  <= '0;
      tlast_r  <= 1'b0;
      tvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      beat_r   <= '0;
      off_r    <= '0;
      seq_r    <= '0;
      drop_r   <= 16'd0;
    end else begin
      state_r  <= state_n_s;
      shadow_r <= shadow_n_s;
      tdata_r  <= tdata_n_s;
      tkeep_r  <= tkeep_n_s;
      tlast_r  <= tlast_n_s;
      tvalid_r <= tvalid_n_s;
      busy_r   <= busy_n_s;
      beat_r   <= beat_n_s;
      off_r    <= off_n_s;
      seq_r    <= seq_n_s;
      drop_r   <= drop_n_s;
    end
  end

  assign busy          = busy_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tkeep  = tkeep_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign seq_num       = seq_r;
  assign drop_count    = drop_r;

endmodule

// File: tb/tb_pbit_frame_packer.sv
// -----------------------------------------------------------------------------
// Bench for pbit_frame_packer. Two instances share stimulus: one with the
// default 1024/256 geometry (4 beats) and one with 300 p-bits (2 beats, a
// partial last beat). A reference model predicts every snapshot as a list of
// beats sliced from the captured vector and queues it; a monitor pops and
// compares on every handshake and checks control outputs each cycle.
// -----------------------------------------------------------------------------
module tb_pbit_frame_packer;

  localparam int DW  = 256;
  localparam int KW  = DW / 8;
  localparam int NP0 = 1024;
  localparam int NP1 = 300;
  localparam int FC0 = 4;
  localparam int FC1 = 2;
`ifdef PBIT_PACKER_HEADER_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1023:0] pbits = '0;
  logic          snap_req = 1'b0;
  logic          tready = 1'b1;

  logic [DW-1:0] tdata  [2];
  logic [KW-1:0] tkeep  [2];
  logic          tvalid [2];
  logic          tlast  [2];
  logic          busy   [2];
  logic [31:0]   seq    [2];
  logic [15:0]   drop   [2];

  beat_t       q0[$];
  beat_t       q1[$];
  int          pend [2] = '{0, 0};
  logic [31:0] mseq [2] = '{32'd0, 32'd0};
  logic [15:0] mdrop[2] = '{16'd0, 16'd0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pbit_frame_packer #(.DATA_WIDTH(DW), .TOTAL_NUM_PBITS(NP0), .SEQ_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .pbits(pbits), .snap_req(snap_req), .busy(busy[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tkeep(tkeep[0]), .m_axis_tvalid(tvalid[0]),
    .m_axis_tready(tready), .m_axis_tlast(tlast[0]), .seq_num(seq[0]),
    .drop_count(drop[0])
  );

  pbit_frame_packer #(.DATA_WIDTH(DW), .TOTAL_NUM_PBITS(NP1), .SEQ_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .pbits(pbits[NP1-1:0]), .snap_req(snap_req), .busy(busy[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tkeep(tkeep[1]), .m_axis_tvalid(tvalid[1]),
    .m_axis_tready(tready), .m_axis_tlast(tlast[1]), .seq_num(seq[1]),
    .drop_count(drop[1])
  );

  task automatic chk(input string nm, input int inst, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, inst, act, exp);
    end
  endtask

  function automatic logic [1023:0] rnd_vec();
    logic [1023:0] r;
    for (int j = 0; j < 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected beats of one snapshot: header (optional), then the captured
  // vector, truncated to n p-bits, cut into 256-bit slices.
  task automatic push_snap(input int inst, input logic [1023:0] v, input logic [31:0] s);
    int            n;
    int            fc;
    logic [1023:0] m;
    logic [31:0]   fcv;
    beat_t         b;
    n  = (inst == 0) ? NP0 : NP1;
    fc = (inst == 0) ? FC0 : FC1;
    m  = v;
    for (int j = n; j < 1024; j++) m[j] = 1'b0;
    if (HDR_BEATS == 1) begin
      fcv = fc;
      b.d = '0;
      b.d[31:0]  = s;
      b.d[47:32] = fcv[15:0];
      b.k = '1;
      b.l = 1'b0;
      if (inst == 0) q0.push_back(b); else q1.push_back(b);
    end
    for (int k = 0; k < fc; k++) begin
      b.d = DW'(m >> (k * DW));
      for (int j = 0; j < KW; j++) b.k[j] = ((k * DW + j * 8) < n);
      b.l = (k == fc - 1);
      if (inst == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Reference model: advances once per clock edge on the same inputs the DUTs see.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          pend[i]  = 0;
          mseq[i]  = 32'd0;
          mdrop[i] = 16'd0;
        end
        q0.delete();
        q1.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (snap_req && (pend[i] == 0 || (pend[i] == 1 && tready))) begin
            mseq[i] = mseq[i] + 32'd1;
            push_snap(i, pbits, mseq[i]);
            pend[i] = ((i == 0) ? FC0 : FC1) + HDR_BEATS;
          end else begin
            if (snap_req && pend[i] > 0 && mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 16'd1;
            if (pend[i] > 0 && tready) pend[i] = pend[i] - 1;
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, away from the DUTs' active edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          chk("rst_tvalid", i, DW'(tvalid[i]), '0);
          chk("rst_busy",   i, DW'(busy[i]),   '0);
          chk("rst_tlast",  i, DW'(tlast[i]),  '0);
          chk("rst_tdata",  i, tdata[i],       '0);
          chk("rst_tkeep",  i, DW'(tkeep[i]),  '0);
          chk("rst_seq",    i, DW'(seq[i]),    '0);
          chk("rst_drop",   i, DW'(drop[i]),   '0);
        end else begin
          chk("tvalid", i, DW'(tvalid[i]), DW'(pend[i] > 0));
          chk("busy",   i, DW'(busy[i]),   DW'(pend[i] > 0));
          chk("seq",    i, DW'(seq[i]),    DW'(mseq[i]));
          chk("drop",   i, DW'(drop[i]),   DW'(mdrop[i]));
          if (tvalid[i] && tready) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              chk("unexpected_beat", i, DW'(1), DW'(0));
            end else begin
              if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
              chk("tdata", i, tdata[i],       e.d);
              chk("tkeep", i, DW'(tkeep[i]),  DW'(e.k));
              chk("tlast", i, DW'(tlast[i]),  DW'(e.l));
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Alternating 0xA5 pattern, single request, always ready.
    pbits = {128{8'hA5}};
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (8) tick();

    // Back-pressure every other cycle while pbits keep moving.
    pbits = rnd_vec();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tready = ~tready;
      pbits = rnd_vec();
      tick();
    end
    tready = 1'b1;
    repeat (6) tick();

    // Request held high: back-to-back snapshots plus drops in between.
    snap_req = 1'b1;
    for (int c = 0; c < 14; c++) begin
      pbits = rnd_vec();
      tick();
    end
    snap_req = 1'b0;
    repeat (8) tick();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      snap_req = ($urandom_range(0, 3) == 0);
      tready   = ($urandom_range(0, 3) != 0);
      pbits    = rnd_vec();
      tick();
    end
    snap_req = 1'b0;
    tready   = 1'b1;
    repeat (8) tick();

    // Reset while beat 2 is on the bus, then a fresh capture.
    pbits = rnd_vec();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pbits = rnd_vec();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;

    // Drain with a bounded budget.
    for (int t = 0; t < 50 && (pend[0] != 0 || pend[1] != 0); t++) tick();
    tick();
    chk("drain_q0",   0, DW'(q0.size()), '0);
    chk("drain_q1",   1, DW'(q1.size()), '0);
    chk("drain_pend", 0, DW'(pend[0]),   '0);
    chk("drain_pend", 1, DW'(pend[1]),   '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pbit_frame_packer.md
PBIT_FRAME_PACKER -- requirements
Module: pbit_frame_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: stream beat width in bits, a multiple of 8.
REQ-002 SHALL have parameter TOTAL_NUM_PBITS, default 1024: p-bit vector width, any value of 1 or more.
REQ-003 SHALL have parameter SEQ_WIDTH, default 32: snapshot sequence counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pbits, input, TOTAL_NUM_PBITS bits: live p-bit states.
REQ-007 SHALL have port snap_req, input, 1 bit: request to capture and stream one snapshot.
REQ-008 SHALL have port busy, output, 1 bit: a snapshot is in flight.
REQ-009 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-010 SHALL have port m_axis_tkeep, output, DATA_WIDTH/8 bits: valid-byte mask.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit; and port m_axis_tready, input, 1 bit: stream handshake.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: marks the final beat of a snapshot.
REQ-013 SHALL have port seq_num, output, SEQ_WIDTH bits: count of accepted snapshots.
REQ-014 SHALL have port drop_count, output, 16 bits: count of snap_req pulses ignored, saturating.

Function
REQ-015 SHALL define FRAME_COUNT as ceil(TOTAL_NUM_PBITS/DATA_WIDTH) beats per snapshot.
REQ-016 SHALL implement states IDLE and SEND, plus HDR when the header feature is enabled; busy SHALL be high in every state except IDLE.
REQ-017 SHALL, on snap_req sampled high in IDLE, register pbits into a shadow register, increment seq_num (wrapping modulo 2^SEQ_WIDTH), and enter SEND (or HDR) on the next edge.
REQ-018 SHALL assert m_axis_tvalid in the cycle after snap_req is accepted, presenting beat 0 = shadow[DATA_WIDTH-1:0].
REQ-019 SHALL present beat k = shadow[k*DATA_WIDTH +: DATA_WIDTH], using an incrementing bit offset rather than a multiplier.
REQ-020 SHALL advance the beat only when tvalid and tready are both high; while tvalid=1 and tready=0, tdata, tkeep and tlast SHALL hold stable.
REQ-021 SHALL assert tlast on beat FRAME_COUNT-1 only.
REQ-022 SHALL zero-pad the bits above TOTAL_NUM_PBITS in the last beat; on that beat, tkeep SHALL set the lowest ceil(remaining bits/8) bytes, and SHALL be all ones on every other beat.
REQ-023 SHALL, when the last beat handshakes, return to IDLE; if snap_req is high in that same cycle, it SHALL be accepted as a new capture and the module SHALL go directly to SEND/HDR with no idle gap.
REQ-024 SHALL, on snap_req high while busy (except as in REQ-023), ignore the request, leave the shadow register unchanged, and increment drop_count, saturating at 0xFFFF.
REQ-025 SHALL keep the shadow register constant for the whole snapshot, regardless of changes on pbits.
REQ-026 SHALL handle FRAME_COUNT=1 with a single beat that has tlast=1.

Reset
REQ-027 SHALL, while rst is high (asynchronous assertion), force state=IDLE, busy=0, tvalid=0, tlast=0, tdata=0, tkeep=0, seq_num=0, drop_count=0 and beat index=0.
REQ-028 SHALL, if rst asserts mid-snapshot, abandon the snapshot with no further beats, and accept the first snap_req after rst deasserts as a fresh capture.

Configuration
REQ-029 SHALL, when the macro PBIT_PACKER_HEADER_EN is defined, emit a header beat before beat 0 in state HDR: tdata = {zeros, FRAME_COUNT[15:0], seq_num}, tkeep all ones, tlast=0; this header beat obeys the same handshake rules.
REQ-030 SHALL, when PBIT_PACKER_HEADER_EN is undefined, have no HDR state, with exactly FRAME_COUNT beats per snapshot.

Verification
REQ-031 SHALL cover: defaults, pbits=alternating 0xA5 pattern, tready=1, one snap_req -> 4 beats on consecutive cycles, tlast on beat 3 only, seq_num=1.
REQ-032 SHALL cover: TOTAL_NUM_PBITS=300, DATA_WIDTH=256 -> 2 beats, beat 1 bits[43:0] valid and upper bits zero, tkeep=0x3F.
REQ-033 SHALL cover: tready toggling every other cycle, pbits changing every cycle -> tdata stable while stalled, beats match the value captured at the snap_req edge.
REQ-034 SHALL cover: snap_req held high continuously with tready=1 -> back-to-back snapshots with no gap, seq_num counting 1,2,3; extra pulses during SEND -> drop_count increments.
REQ-035 SHALL cover: rst pulsed during beat 2 -> outputs return to their REQ-027 values immediately, and the next snap_req starts again at beat 0.
REQ-036 SHALL cover: PBIT_PACKER_HEADER_EN defined -> first beat is the header with seq_num, then the 4 data beats, tlast on the 5th beat.
